// File: rtl/count_display_pkg.sv
// Shared types, sizes and the active-low seven-segment table for count_display.
package count_display_pkg;

  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned BCD_DIGITS = 5;
  localparam int unsigned BIN_W      = 16;
  localparam int unsigned BCD_W      = 4 * BCD_DIGITS;
  localparam int unsigned DIG_W      = 4 * NUM_DIGITS;
  localparam int unsigned IDX_W      = $clog2(NUM_DIGITS);
  localparam int unsigned SEG_W      = 7;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  // Segments {g,f,e,d,c,b,a}, active-low; entry 15 first.
  localparam logic [15:0][SEG_W-1:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_e;

endpackage

// File: rtl/bin2bcd16.sv
// Sequential 16-bit binary to 5-digit BCD converter (double-dabble), one bit per cycle.
// Only built when COUNT_DISPLAY_DECIMAL_EN is defined.
`ifdef COUNT_DISPLAY_DECIMAL_EN
module bin2bcd16
  import count_display_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [BIN_W-1:0] bin,
  input  logic             stable,
  output logic [BCD_W-1:0] bcd,
  output logic             busy
);

  conv_state_e      state;
  logic [BIN_W-1:0] bin_sh;
  logic [BIN_W-1:0] conv_val;
  logic [BIN_W-1:0] last_conv;
  logic [BCD_W-1:0] scratch;
  logic [3:0]       iter;
  logic             force_conv;
  logic             start_c;
  logic [BCD_W-1:0] adj_c;

  assign start_c = (stable && (bin != last_conv)) || force_conv;

  // Add-3 correction applied to every nibble before the shift.
  always_comb begin
    adj_c = scratch;
    for (int i = 0; i < int'(BCD_DIGITS); i++) begin
      if (scratch[4*i +: 4] >= 4'd5) adj_c[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      bin_sh     <= '0;
      conv_val   <= '0;
      last_conv  <= '0;
      scratch    <= '0;
      iter       <= '0;
      force_conv <= 1'b1;
      bcd        <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_c) begin
            bin_sh   <= bin;
            conv_val <= bin;
            scratch  <= '0;
            iter     <= '0;
            busy     <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          {scratch, bin_sh} <= {adj_c[BCD_W-2:0], bin_sh, 1'b0};
          iter <= iter + 4'd1;
          if (iter == 4'd15) state <= DONE;
        end
        DONE: begin
          bcd        <= scratch;
          last_conv  <= conv_val;
          force_conv <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`endif

// File: rtl/count_display.sv
// Renders the 16-bit counter value on an 8-digit multiplexed common-anode display.
// COUNT_DISPLAY_DECIMAL_EN selects decimal with leading-zero blanking; otherwise 4-digit hex.
module count_display
  import count_display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000
)
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [BIN_W-1:0]      count_i,
  output logic [SEG_W-1:0]      seg_o,
  output logic                  dp_o,
  output logic [NUM_DIGITS-1:0] an_o,
  output logic                  busy_o
);

  localparam int unsigned RCNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  logic [BIN_W-1:0]  s1;
  logic [BIN_W-1:0]  s2;
  logic              stable_c;
  logic [DIG_W-1:0]  digits_c;
  logic [RCNT_W-1:0] rcnt;
  logic [IDX_W-1:0]  digit_idx;
  logic [IDX_W+1:0]  sh_c;
  logic [3:0]        nib_c;
  logic              blank_c;

  // Two-register capture isolates the counter's domain; equal stages mean a settled sample.
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= count_i;
      s2 <= s1;
    end
  end

  assign stable_c = (s1 == s2);

`ifdef COUNT_DISPLAY_DECIMAL_EN
  logic [BCD_W-1:0] disp_bcd;

  bin2bcd16 u_conv (
    .clk    (clk),
    .reset  (reset),
    .bin    (s2),
    .stable (stable_c),
    .bcd    (disp_bcd),
    .busy   (busy_o)
  );

  assign digits_c = DIG_W'(disp_bcd);
`else
  logic [BIN_W-1:0] disp_hex;

  always_ff @(posedge clk) begin
    if (!reset) disp_hex <= '0;
    else if (stable_c) disp_hex <= s2;
  end

  assign digits_c = DIG_W'(disp_hex);
  assign busy_o   = 1'b0;
`endif

  assign sh_c  = {digit_idx, 2'b00};
  assign nib_c = digits_c[sh_c +: 4];

  // A digit is blank when it is outside the shown range or is a leading zero.
  always_comb begin
    blank_c = 1'b0;
`ifdef COUNT_DISPLAY_DECIMAL_EN
    if (digit_idx >= IDX_W'(BCD_DIGITS)) blank_c = 1'b1;
    else if ((digit_idx != '0) && ((digits_c >> sh_c) == '0)) blank_c = 1'b1;
`else
    if (digit_idx >= IDX_W'(4)) blank_c = 1'b1;
`endif
  end

  // Refresh counter and digit scanner; segment/anode outputs lag the digit index by one cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rcnt      <= '0;
      digit_idx <= '0;
      seg_o     <= SEG_BLANK;
      an_o      <= '1;
      dp_o      <= 1'b1;
    end else begin
      if (rcnt == RCNT_W'(REFRESH_DIV - 1)) begin
        rcnt      <= '0;
        digit_idx <= digit_idx + IDX_W'(1);
      end else begin
        rcnt <= rcnt + RCNT_W'(1);
      end
      seg_o <= blank_c ? SEG_BLANK : SEG_TABLE[nib_c];
      an_o  <= blank_c ? '1 : ~(NUM_DIGITS'(1) << digit_idx);
      dp_o  <= 1'b1;
    end
  end

endmodule
